// File: rtl/attn_score_mac.sv
// attn_score_mac: streaming q.k dot-product scorer.
// Alternating q/k words accumulate into one saturated score per vector.
module attn_score_mac #(
  parameter int DATA_W    = 8,
  parameter int N_FEAT    = 4,
  parameter int OUT_SHIFT = DATA_W - 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic signed [DATA_W-1:0] m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     busy
);

  localparam int CNT_W = $clog2(N_FEAT);
  localparam int ACC_W = 2 * DATA_W + CNT_W;
  localparam int PRD_W = 2 * DATA_W;

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(N_FEAT - 1);
  localparam logic signed [ACC_W-1:0] SAT_HI =
    ACC_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO =
    ~SAT_HI;

  typedef enum logic {
    ST_Q = 1'b0,
    ST_K = 1'b1
  } state_t;

  state_t                    r_state;
  logic signed [DATA_W-1:0]  r_q;
  logic        [CNT_W-1:0]   r_cnt;
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [DATA_W-1:0]  r_mdata;
  logic                      r_mvalid;

  logic                      w_last;
  logic                      w_xfer;
  logic                      w_load;
  logic signed [PRD_W-1:0]   w_prod;
  logic signed [ACC_W-1:0]   w_prod_x;
  logic signed [ACC_W-1:0]   w_sum;
  logic signed [ACC_W-1:0]   w_shr;
  logic signed [DATA_W-1:0]  w_sat;

  // The last k word cannot land while an old score is still unread.
  assign w_last  = (r_state == ST_K) && (r_cnt == LAST);
  assign s_ready = !(w_last && r_mvalid && !m_ready);
  assign w_xfer  = s_valid && s_ready;
  assign w_load  = w_xfer && w_last;

  assign w_prod   = r_q * s_data;
  assign w_prod_x = {{CNT_W{w_prod[PRD_W-1]}}, w_prod};
  assign w_sum    = (r_cnt == '0) ? w_prod_x
                                  : r_acc + w_prod_x;
  assign w_shr    = w_sum >>> OUT_SHIFT;

  assign m_data  = r_mdata;
  assign m_valid = r_mvalid;
  assign busy    = (r_cnt != '0) || (r_state == ST_K);

  // Clamp the scaled sum into the output range.
  always_comb begin
    w_sat = w_shr[DATA_W-1:0];
    if (w_shr > SAT_HI)
      w_sat = SAT_HI[DATA_W-1:0];
    else if (w_shr < SAT_LO)
      w_sat = SAT_LO[DATA_W-1:0];
  end

  // q/k FSM, accumulator and output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_Q;
      r_q      <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mdata  <= '0;
      r_mvalid <= 1'b0;
    end else begin
      if (w_xfer) begin
        unique case (r_state)
          ST_Q: begin
            r_q     <= s_data;
            r_state <= ST_K;
          end
          ST_K: begin
            r_acc   <= w_sum;
            r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
            r_state <= ST_Q;
          end
          default: r_state <= ST_Q;
        endcase
      end
      if (w_load) begin
        r_mdata  <= w_sat;
        r_mvalid <= 1'b1;
      end else if (r_mvalid && m_ready) begin
        r_mvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_attn_score_mac.sv
// tb_attn_score_mac: directed + random scoreboard bench.
// Instance A: DATA_W=8 N_FEAT=4; instance B: DATA_W=6 N_FEAT=8.
module tb_attn_score_mac;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic signed [7:0] a_data = '0;
  logic              a_valid = 1'b0;
  logic              a_ready;
  logic signed [7:0] a_mdata;
  logic              a_mvalid;
  logic              a_mready = 1'b1;
  logic              a_busy;

  logic signed [5:0] b_data = '0;
  logic              b_valid = 1'b0;
  logic              b_ready;
  logic signed [5:0] b_mdata;
  logic              b_mvalid;
  logic              b_mready = 1'b1;
  logic              b_busy;

  int checks = 0;
  int failures = 0;
  int vq [64];
  int vk [64];
  longint exp_a [$];
  longint exp_b [$];
  bit rnd_a = 1'b0;
  bit rnd_b = 1'b0;
  bit gaps = 1'b0;

  always #5 clk = ~clk;

  attn_score_mac #(
    .DATA_W(8), .N_FEAT(4), .OUT_SHIFT(7)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .s_data(a_data), .s_valid(a_valid),
    .s_ready(a_ready), .m_data(a_mdata),
    .m_valid(a_mvalid), .m_ready(a_mready),
    .busy(a_busy)
  );

  attn_score_mac #(
    .DATA_W(6), .N_FEAT(8), .OUT_SHIFT(5)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .s_data(b_data), .s_valid(b_valid),
    .s_ready(b_ready), .m_data(b_mdata),
    .m_valid(b_mvalid), .m_ready(b_mready),
    .busy(b_busy)
  );

  task automatic chk(input string tag,
                     input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  // Reference: exact sum, arithmetic shift, clamp.
  function automatic longint score(input int n,
                                   input int dw,
                                   input int sh);
    longint s = 0;
    longint hi = (longint'(1) <<< (dw - 1)) - 1;
    for (int i = 0; i < n; i++)
      s += longint'(vq[i]) * longint'(vk[i]);
    s = s >>> sh;
    if (s > hi) s = hi;
    if (s < -hi - 1) s = -hi - 1;
    return s;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic gap();
    if (gaps && $urandom_range(0, 3) == 0)
      idle($urandom_range(1, 3));
  endtask

  task automatic put_a(input int v);
    int n = 0;
    a_data = 8'(v);
    a_valid = 1'b1;
    @(negedge clk);
    while (!a_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!a_ready) chk("a_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    a_valid = 1'b0;
  endtask

  task automatic put_b(input int v);
    int n = 0;
    b_data = 6'(v);
    b_valid = 1'b1;
    @(negedge clk);
    while (!b_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!b_ready) chk("b_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    b_valid = 1'b0;
  endtask

  task automatic vec_a();
    exp_a.push_back(score(4, 8, 7));
    for (int i = 0; i < 4; i++) begin
      gap();
      put_a(vq[i]);
      gap();
      put_a(vk[i]);
    end
  endtask

  task automatic vec_b();
    exp_b.push_back(score(8, 6, 5));
    for (int i = 0; i < 8; i++) begin
      gap();
      put_b(vq[i]);
      gap();
      put_b(vk[i]);
    end
  endtask

  task automatic fill(input int q0, input int k0,
                      input int qr, input int kr);
    for (int i = 0; i < 64; i++) begin
      vq[i] = (i == 0) ? q0 : qr;
      vk[i] = (i == 0) ? k0 : kr;
    end
  endtask

  // Scoreboard: pop and compare on each output handshake.
  always @(negedge clk) begin
    if (rst_n && a_mvalid && a_mready) begin
      if (exp_a.size() == 0)
        chk("a_unexpected_out", 1, 0);
      else
        chk("a_score", a_mdata, exp_a.pop_front());
    end
    if (rst_n && b_mvalid && b_mready) begin
      if (exp_b.size() == 0)
        chk("b_unexpected_out", 1, 0);
      else
        chk("b_score", b_mdata, exp_b.pop_front());
    end
  end

  // Random downstream stalls during the random runs.
  always @(posedge clk) begin
    #1;
    if (rnd_a) a_mready = ($urandom_range(0, 2) != 0);
    if (rnd_b) b_mready = ($urandom_range(0, 2) != 0);
  end

  initial begin
    int n;
    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", a_ready, 1);
    chk("rst_busy", a_busy, 0);
    chk("rst_m_valid", a_mvalid, 0);
    chk("rst_m_data", a_mdata, 0);
    chk("rst_b_s_ready", b_ready, 1);
    chk("rst_b_m_valid", b_mvalid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_s_ready", a_ready, 1);
    chk("post_rst_busy", a_busy, 0);
    @(posedge clk);
    #1;

    // Basic vector, single output pulse.
    fill(64, 32, 64, 32);
    exp_a.push_back(64);
    put_a(64);
    chk("busy_after_q", a_busy, 1);
    put_a(32);
    chk("busy_after_k", a_busy, 1);
    for (int i = 1; i < 4; i++) begin
      put_a(64);
      put_a(32);
    end
    chk("basic_m_valid", a_mvalid, 1);
    chk("basic_m_data", a_mdata, 64);
    chk("basic_busy", a_busy, 0);
    idle(1);
    chk("basic_pulse_end", a_mvalid, 0);

    // Saturation both ways.
    fill(127, 127, 127, 127);
    vec_a();
    chk("sat_hi", a_mdata, 127);
    fill(-128, 127, -128, 127);
    vec_a();
    chk("sat_lo", a_mdata, -128);

    // Truncation toward -inf.
    fill(-1, 1, 0, 0);
    vec_a();
    chk("trunc_neg", a_mdata, -1);
    fill(1, 1, 0, 0);
    vec_a();
    chk("trunc_pos", a_mdata, 0);
    idle(1);

    // Backpressure: second vector overlaps a held score.
    a_mready = 1'b0;
    fill(64, 32, 64, 32);
    vec_a();
    exp_a.push_back(32);
    for (int i = 0; i < 3; i++) begin
      put_a(32);
      put_a(32);
    end
    put_a(32);
    a_data = 8'sd32;
    a_valid = 1'b1;
    @(negedge clk);
    chk("bp_s_ready_low", a_ready, 0);
    chk("bp_hold_valid", a_mvalid, 1);
    chk("bp_hold_data", a_mdata, 64);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_s_ready_low2", a_ready, 0);
    chk("bp_hold_data2", a_mdata, 64);
    @(posedge clk);
    #1;
    a_mready = 1'b1;
    @(negedge clk);
    chk("bp_s_ready_comb", a_ready, 1);
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    a_mready = 1'b0;
    chk("bp_reload_valid", a_mvalid, 1);
    chk("bp_reload_data", a_mdata, 32);
    a_mready = 1'b1;
    idle(1);
    chk("bp_drained", a_mvalid, 0);

    // Reset mid-vector.
    put_a(64);
    put_a(32);
    put_a(64);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    chk("midrst_busy", a_busy, 0);
    chk("midrst_m_valid", a_mvalid, 0);
    chk("midrst_s_ready", a_ready, 1);
    fill(64, 32, 64, 32);
    vec_a();
    chk("midrst_m_data", a_mdata, 64);
    idle(2);

    // Random run, instance A.
    gaps = 1'b1;
    rnd_a = 1'b1;
    for (int v = 0; v < 1000; v++) begin
      for (int i = 0; i < 4; i++) begin
        vq[i] = int'($urandom_range(0, 255)) - 128;
        vk[i] = int'($urandom_range(0, 255)) - 128;
      end
      vec_a();
    end
    rnd_a = 1'b0;
    @(posedge clk);
    #2;
    a_mready = 1'b1;
    n = 0;
    while (exp_a.size() != 0 && n < 100) begin
      idle(1);
      n++;
    end
    chk("a_drain_left", exp_a.size(), 0);

    // Random run, instance B.
    rnd_b = 1'b1;
    for (int v = 0; v < 1000; v++) begin
      for (int i = 0; i < 8; i++) begin
        vq[i] = int'($urandom_range(0, 63)) - 32;
        vk[i] = int'($urandom_range(0, 63)) - 32;
      end
      vec_b();
    end
    rnd_b = 1'b0;
    @(posedge clk);
    #2;
    b_mready = 1'b1;
    n = 0;
    while (exp_b.size() != 0 && n < 100) begin
      idle(1);
      n++;
    end
    chk("b_drain_left", exp_b.size(), 0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
